tlu_tx_multi: RTL
=================

TLU_TX_MULTI -- requirements
Module: tlu_tx_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of TLU/DUT channels, 1..8.
REQ-002 SHALL have parameter ID_WIDTH, default 31: trigger ID bits, 1..31.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, >=2.
REQ-004 SHALL have parameter INV_OUT, default 0: 1 inverts all TLU_* inputs and outputs at the pins.
REQ-005 SHALL have SYS_CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have SYS_RST_N  in  1  asynchronous active-low reset.
REQ-007 SHALL have ENABLE  in  1  block enable; CH_MASK  in  N_CH  channels participating.
REQ-008 SHALL have MODE  in  2  0=no handshake, 1=simple handshake, 2=trigger-data handshake, 3=treated as 1.
REQ-009 SHALL have TRIG  in  1  trigger request pulse; TRIG_ID  in  ID_WIDTH; N_BITS  in  5  ID bits to send.
REQ-010 SHALL have CONF_TIME_OUT  in  16  timeout in SYS_CLK cycles, 0=disabled.
REQ-011 SHALL have READY  out  1; TIME_OUT  out  1 pulse; TO_CH  out  N_CH offending channels; STATE_OUT  out  3; TRIG_CNT  out  32 accepted triggers.
REQ-012 SHALL have TLU_CLOCK  in  N_CH; TLU_BUSY  in  N_CH; TLU_TRIGGER  out  N_CH; TLU_RESET  out  N_CH.

Function
REQ-013 TLU_CLOCK/TLU_BUSY SHALL pass SYNC_STAGES flops; clock edge = synced rising edge, single-cycle strobe per channel.
REQ-014 FSM states (one-hot, = STATE_OUT): IDLE 3'b001, TRIG 3'b010, READ 3'b100; GUARD reported as 3'b000.
REQ-015 Accept = IDLE & READY & TRIG & ENABLE & CH_MASK!=0; on accept: ACT_MASK<=CH_MASK, per-channel SR<={TRIG_ID,1'b0}, timeout counter<=CONF_TIME_OUT, TRIG_CNT+1 (wraps 2^32-1->0), go TRIG.
REQ-016 TRIG not accepted SHALL be dropped silently; CH_MASK changes mid-handshake SHALL not affect ACT_MASK.
REQ-017 MODE 0: TRIG state lasts exactly 4 cycles, then GUARD; busy ignored.
REQ-018 MODE 1/2: TRIG->READ when all ACT_MASK channels busy (AND); READ->GUARD when all ACT_MASK channels released (NOR).
REQ-019 MODE 2: in READ, channel c SR shifts right on its own clock strobe; bits at index >= N_BITS cleared; N_BITS>ID_WIDTH clamped to ID_WIDTH. MODE 1: no shift.
REQ-020 TLU_TRIGGER[c] registered = ACT_MASK[c] & (state==TRIG | (MODE==2 & state==READ & SR[c][0])); 1-cycle latency from state.
REQ-021 Timeout: counter decrements in TRIG/READ; reaching 0 with CONF_TIME_OUT!=0 SHALL pulse TIME_OUT one cycle, latch TO_CH (TRIG: active channels not busy; READ: active channels still busy), go GUARD.
REQ-022 TO_CH SHALL hold until next accept, which clears it.
REQ-023 GUARD SHALL last 4 cycles then IDLE; any channel clock strobe during GUARD restarts the 4-cycle count.
REQ-024 READY = (IDLE & no clock strobe in previous cycle) | !ENABLE.
REQ-025 ENABLE=0 SHALL force IDLE next cycle, clear SRs, outputs inactive; STATE_OUT=0.
REQ-026 Timeout and busy transition in the same cycle: timeout wins.
REQ-027 TLU_RESET SHALL be constant inactive (0 before inversion).

Reset
REQ-028 SYS_RST_N low SHALL immediately force IDLE, SRs/counters/TO_CH/TRIG_CNT=0, TIME_OUT=0, TLU_TRIGGER/TLU_RESET=INV_OUT level-inactive, READY per REQ-024, including mid-handshake.
REQ-029 Synchronizer flops SHALL also reset; first accept possible on the first cycle after release.

Verification
REQ-030 MODE 2, N_CH=4, CH_MASK=4'b0101, TRIG_ID=0x15, N_BITS=5; ch0/ch2 raise busy then clock 6 times -> each active TLU_TRIGGER shows 1 (TRIG) then 1,0,1,0,1 per own clock edge; ch1/ch3 stay 0; TRIG_CNT=1.
REQ-031 MODE 1, CONF_TIME_OUT=10, ch2 never busy -> TIME_OUT pulse 10 cycles after accept, TO_CH=4'b0100, GUARD 4 cycles, READY high again.
REQ-032 MODE 0 -> TLU_TRIGGER high exactly 4 cycles, READY low 8 cycles total, busy ignored.
REQ-033 SYS_RST_N asserted during READ with TLU_TRIGGER high -> outputs inactive same cycle, STATE_OUT=3'b001 after release.
REQ-034 INV_OUT=1 repeat REQ-030 -> all TLU pins inverted, identical decoded ID.
REQ-035 TRIG during GUARD, and TRIG with CH_MASK=0 -> no accept, TRIG_CNT unchanged.

Source files
------------

// File: rtl/tlu_tx_multi.sv
// tlu_tx_multi: multi-channel TLU trigger transmitter with busy handshake,
// per-channel serial trigger-ID shift-out, timeout detection and guard interval.
module tlu_tx_multi #(
  parameter int N_CH        = 4,
  parameter int ID_WIDTH    = 31,
  parameter int SYNC_STAGES = 2,
  parameter int INV_OUT     = 0
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST_N,
  input  logic                ENABLE,
  input  logic [N_CH-1:0]     CH_MASK,
  input  logic [1:0]          MODE,
  input  logic                TRIG,
  input  logic [ID_WIDTH-1:0] TRIG_ID,
  input  logic [4:0]          N_BITS,
  input  logic [15:0]         CONF_TIME_OUT,
  output logic                READY,
  output logic                TIME_OUT,
  output logic [N_CH-1:0]     TO_CH,
  output logic [2:0]          STATE_OUT,
  output logic [31:0]         TRIG_CNT,
  input  logic [N_CH-1:0]     TLU_CLOCK,
  input  logic [N_CH-1:0]     TLU_BUSY,
  output logic [N_CH-1:0]     TLU_TRIGGER,
  output logic [N_CH-1:0]     TLU_RESET
);
  localparam logic [N_CH-1:0] INV = {N_CH{INV_OUT != 0}};
  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_READ, S_GUARD} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][N_CH-1:0] clk_sh, busy_sh;
  logic [N_CH-1:0] clk_q, strobe, busy, act, trig_q;
  logic [ID_WIDTH:0] sr [N_CH];
  logic [ID_WIDTH:0] keep;
  logic [15:0] to_cnt;
  logic [4:0] nb;
  logic [1:0] phase;
  logic strobe_q, accept, expire, hs, m2;
  assign busy = busy_sh[SYNC_STAGES-1];
  assign strobe = clk_sh[SYNC_STAGES-1] & ~clk_q;
  assign hs = MODE != 2'd0;
  assign m2 = MODE == 2'd2;
  assign READY = (state == S_IDLE && !strobe_q) || !ENABLE;
  assign accept = state == S_IDLE && READY && TRIG && ENABLE && |CH_MASK;
  assign expire = (state == S_TRIG || state == S_READ) && to_cnt == 16'd1;
  assign nb = (N_BITS > 5'(ID_WIDTH)) ? 5'(ID_WIDTH) : N_BITS;
  assign STATE_OUT = !ENABLE ? 3'b000 : state == S_IDLE ? 3'b001 :
                     state == S_TRIG ? 3'b010 : state == S_READ ? 3'b100 : 3'b000;
  assign TLU_TRIGGER = trig_q ^ INV;
  assign TLU_RESET = INV;
  // After each shift the ID bit to send sits at index 0; bits beyond N_BITS are dropped.
  always_comb begin
    keep = '0;
    for (int i = 0; i <= ID_WIDTH; i++) keep[i] = 5'(i) < nb;
  end
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      clk_sh <= '0;
      busy_sh <= '0;
      clk_q <= '0;
      strobe_q <= 1'b0;
      state <= S_IDLE;
      for (int c = 0; c < N_CH; c++) sr[c] <= '0;
      to_cnt <= '0;
      phase <= '0;
      act <= '0;
      trig_q <= '0;
      TO_CH <= '0;
      TRIG_CNT <= '0;
      TIME_OUT <= 1'b0;
    end else begin
      clk_sh <= {clk_sh[SYNC_STAGES-2:0], TLU_CLOCK ^ INV};
      busy_sh <= {busy_sh[SYNC_STAGES-2:0], TLU_BUSY ^ INV};
      clk_q <= clk_sh[SYNC_STAGES-1];
      strobe_q <= |strobe;
      TIME_OUT <= 1'b0;
      if (!ENABLE) begin
        state <= S_IDLE;
        for (int c = 0; c < N_CH; c++) sr[c] <= '0;
        trig_q <= '0;
        to_cnt <= '0;
        phase <= '0;
      end else begin
        for (int c = 0; c < N_CH; c++)
          trig_q[c] <= act[c] & (state == S_TRIG | (m2 & state == S_READ & sr[c][0]));
        if (to_cnt != 16'd0 && (state == S_TRIG || state == S_READ)) to_cnt <= to_cnt - 16'd1;
        case (state)
          S_IDLE: if (accept) begin
            act <= CH_MASK;
            for (int c = 0; c < N_CH; c++) sr[c] <= {TRIG_ID, 1'b0};
            to_cnt <= CONF_TIME_OUT;
            TRIG_CNT <= TRIG_CNT + 32'd1;
            TO_CH <= '0;
            phase <= '0;
            state <= S_TRIG;
          end
          S_TRIG: if (expire) begin
            TIME_OUT <= 1'b1;
            TO_CH <= act & ~busy;
            phase <= '0;
            state <= S_GUARD;
          end else if (hs ? &(busy | ~act) : phase == 2'd3) begin
            phase <= '0;
            state <= hs ? S_READ : S_GUARD;
          end else phase <= phase + 2'd1;
          S_READ: if (expire) begin
            TIME_OUT <= 1'b1;
            TO_CH <= act & busy;
            phase <= '0;
            state <= S_GUARD;
          end else if (!(|(busy & act))) begin
            phase <= '0;
            state <= S_GUARD;
          end else if (m2) begin
            for (int c = 0; c < N_CH; c++) if (strobe[c]) sr[c] <= (sr[c] >> 1) & keep;
          end
          S_GUARD: if (|strobe) phase <= '0;
          else if (phase == 2'd3) state <= S_IDLE;
          else phase <= phase + 2'd1;
        endcase
      end
    end
  end
endmodule
